// File: rtl/count_display_driver.sv
// Binary-to-BCD (sequential double-dabble) converter feeding an eight-digit
// multiplexed common-anode 7-segment display with leading-zero blanking.
module count_display_driver #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int REFRESH_HZ  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] countIn,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        overflow,
    output logic        conv_done
);

    localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [27:0] bin_q, bin_d;
    logic [35:0] bcd_q, bcd_d, bcd_adj;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic        overflow_q, overflow_d;
    logic        conv_done_q, conv_done_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [7:0]  an_q, an_d;
    logic        dp_q, dp_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        overflow_d  = overflow_q;
        conv_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                bin_d   = countIn;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = {bcd_adj[34:0], bin_q[27]};
                bin_d = {bin_q[26:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd27) state_d = DONE;
            end
            DONE: begin
                if (bcd_q[35:32] != 4'd0) begin
                    digits_d   = 32'h9999_9999;
                    overflow_d = 1'b1;
                end else begin
                    digits_d   = bcd_q[31:0];
                    overflow_d = 1'b0;
                end
                conv_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan prescaler, digit index and registered display drive
    logic [31:0] upper;
    logic        blank;
    always_comb begin
        pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + 1'b1;
        idx_d = (pre_q == PW'(DIV - 1)) ? idx_q + 3'd1 : idx_q;
        upper = digits_q >> {idx_q, 2'b00};
        blank = (idx_q != 3'd0) && (upper == 32'd0);
        an_d  = ~(8'b1 << idx_q);
        seg_d = blank ? 7'b1111111 : decode(upper[3:0]);
        dp_d  = ~overflow_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            overflow_q  <= 1'b0;
            conv_done_q <= 1'b0;
            pre_q       <= '0;
            idx_q       <= '0;
            seg_q       <= 7'b1000000;
            an_q        <= 8'b1111_1110;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            conv_done_q <= conv_done_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = dp_q;
    assign overflow  = overflow_q;
    assign conv_done = conv_done_q;

endmodule
